// File: rtl/quad_decoder_if.sv
// Pin, control and status bundle for the quadrature decoder; the bench drives the
// master side and the decoder sits on the slave side.
interface quad_decoder_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             a_in;
    logic             b_in;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             err_clr;
    logic             step;
    logic             dir;
    logic [WIDTH-1:0] count;
    logic             err;

    modport master (
        output enable, a_in, b_in, load, load_val, err_clr,
        input  step, dir, count, err
    );

    modport slave (
        input  enable, a_in, b_in, load, load_val, err_clr,
        output step, dir, count, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync + glitch filter per channel, then a Gray-phase step decoder.
// A stable pin change reaches step/count on edge FILTER_LEN+3; no backpressure, outputs are level/pulse only.
module quad_decoder #(
    parameter int WIDTH      = 4,
    parameter int FILTER_LEN = 3
) (
    input  logic           clk,
    input  logic           reset,
    quad_decoder_if.slave  bus
);
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [1:0] pin;
    logic [1:0] filt;

    assign pin = {bus.a_in, bus.b_in};

    // Bit 1 is channel A, bit 0 is channel B; each channel owns its sync and filter state.
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic           sync1;
        logic           sync2;
        logic           filt_q;
        logic [FCW-1:0] fcnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1  <= 1'b0;
                sync2  <= 1'b0;
                filt_q <= 1'b0;
                fcnt   <= '0;
            end else begin
                sync1 <= pin[c];
                sync2 <= sync1;
                if (sync2 != filt_q) begin
                    if (fcnt == FCW'(FILTER_LEN - 1)) begin
                        filt_q <= sync2;
                        fcnt   <= '0;
                    end else begin
                        fcnt <= fcnt + FCW'(1);
                    end
                end else begin
                    fcnt <= '0;
                end
            end
        end

        assign filt[c] = filt_q;
    end

    // Position of a pair along the up sequence 00 -> 10 -> 11 -> 01.
    function automatic logic [1:0] phase_of(input logic [1:0] p);
        logic [1:0] ph;
        ph = 2'd0;
        case (p)
            2'b00:   ph = 2'd0;
            2'b10:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    logic [1:0]       prev;
    logic [1:0]       delta;
    logic             is_up;
    logic             is_dn;
    logic             is_bad;
    logic             step_q;
    logic             dir_q;
    logic             err_q;
    logic [WIDTH-1:0] count_q;

    // Phase difference mod 4: +1 is up, -1 is down, 2 means both bits flipped at once.
    assign delta  = phase_of(filt) - phase_of(prev);
    assign is_up  = (delta == 2'd1);
    assign is_dn  = (delta == 2'd3);
    assign is_bad = (delta == 2'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= 2'b00;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            prev   <= filt;
            step_q <= bus.enable && (is_up || is_dn);

            if (is_up) begin
                dir_q <= 1'b1;
            end else if (is_dn) begin
                dir_q <= 1'b0;
            end

            if (bus.load) begin
                count_q <= bus.load_val;
            end else if (bus.enable && is_up) begin
                count_q <= count_q + WIDTH'(1);
            end else if (bus.enable && is_dn) begin
                count_q <= count_q - WIDTH'(1);
            end

            if (is_bad) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.step  = step_q;
    assign bus.dir   = dir_q;
    assign bus.count = count_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Randomized bench for quad_decoder against a phase-position model of the encoder.
module tb_quad_decoder;
    localparam int W   = 4;
    localparam int FL  = 3;
    localparam int LAT = FL + 3;
    localparam int WIN = FL + 9;

    logic clk = 1'b0;
    logic reset;

    quad_decoder_if #(.WIDTH(W)) bus ();

    quad_decoder #(.WIDTH(W), .FILTER_LEN(FL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: encoder position 0..3 along the up sequence plus expected outputs.
    logic [1:0]   seq [4];
    int           m_pos;
    logic [W-1:0] m_cnt;
    logic         m_dir;
    logic         m_err;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive_pair(input logic [1:0] p);
        bus.a_in = p[1];
        bus.b_in = p[0];
    endtask

    task automatic run_window(input int load_at, input logic [W-1:0] lval, input int clr_at,
                              output int n_steps, output int first_edge);
        n_steps    = 0;
        first_edge = -1;
        for (int e = 1; e <= WIN; e++) begin
            bus.load     = (e == load_at);
            bus.load_val = lval;
            bus.err_clr  = (e == clr_at);
            @(posedge clk);
            #1;
            if (bus.step === 1'b1) begin
                n_steps++;
                if (first_edge < 0) first_edge = e;
            end
        end
        bus.load    = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_count"}, int'(bus.count), int'(m_cnt));
        chk({tag, "_dir"},   int'(bus.dir),   int'(m_dir));
        chk({tag, "_err"},   int'(bus.err),   int'(m_err));
    endtask

    // op: 0 up, 1 down, 2 illegal, 3 glitch, 4 err_clr, 5 idle load
    // flag: load on the step edge for up/down, err_clr on the error edge for illegal
    task automatic do_op(input int op, input logic en, input logic [W-1:0] lv, input logic flag);
        int ns, fe, la, ca, exp_steps, glen;
        logic [1:0] gp;
        la = 0; ca = 0; exp_steps = 0;
        bus.enable = en;
        case (op)
            0, 1: begin
                m_pos = (op == 0) ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
                drive_pair(seq[m_pos]);
                m_dir = (op == 0);
                if (en) begin
                    exp_steps = 1;
                    m_cnt = (op == 0) ? m_cnt + 1'b1 : m_cnt - 1'b1;
                end
                if (flag) begin
                    la    = LAT;
                    m_cnt = lv;
                end
            end
            2: begin
                m_pos = (m_pos + 2) % 4;
                drive_pair(seq[m_pos]);
                m_err = 1'b1;
                if (flag) ca = LAT;
            end
            3: begin
                glen = $urandom_range(1, FL - 1);
                gp   = seq[m_pos] ^ (($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
                drive_pair(gp);
                repeat (glen) begin
                    @(posedge clk);
                    #1;
                    if (bus.step === 1'b1) chk("glitch_step_early", 1, 0);
                end
                drive_pair(seq[m_pos]);
            end
            4: begin
                ca    = 2;
                m_err = 1'b0;
            end
            default: begin
                la    = 2;
                m_cnt = lv;
            end
        endcase
        run_window(la, lv, ca, ns, fe);
        chk("steps", ns, exp_steps);
        if (exp_steps == 1) chk("step_edge", fe, LAT);
        check_state("op");
    endtask

    initial begin
        seq[0] = 2'b00; seq[1] = 2'b10; seq[2] = 2'b11; seq[3] = 2'b01;
        m_pos = 0; m_cnt = '0; m_dir = 1'b0; m_err = 1'b0;

        reset        = 1'b1;
        bus.enable   = 1'b1;
        bus.a_in     = 1'b0;
        bus.b_in     = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.err_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_step", int'(bus.step), 0);
        check_state("rst");
        reset = 1'b0;

        // Four up steps from reset, then wrap down from zero.
        for (int i = 0; i < 4; i++) do_op(0, 1'b1, '0, 1'b0);
        do_op(5, 1'b1, 4'd0, 1'b0);
        do_op(1, 1'b1, '0, 1'b0);
        do_op(5, 1'b1, 4'd15, 1'b0);
        do_op(0, 1'b1, '0, 1'b0);
        do_op(3, 1'b1, '0, 1'b0);
        do_op(2, 1'b1, '0, 1'b0);
        do_op(4, 1'b1, '0, 1'b0);
        do_op(2, 1'b1, '0, 1'b1);
        do_op(4, 1'b1, '0, 1'b0);
        do_op(0, 1'b1, 4'd9, 1'b1);
        for (int i = 0; i < 3; i++) do_op(0, 1'b0, '0, 1'b0);
        do_op(0, 1'b1, '0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            do_op(int'($urandom_range(0, 5)), ($urandom_range(0, 4) != 0),
                  W'($urandom), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a 01 -> 00 transition must leave no trace.
        while (m_pos != 3) do_op(0, 1'b1, '0, 1'b0);
        drive_pair(2'b00);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        m_pos = 0; m_cnt = '0; m_dir = 1'b0; m_err = 1'b0;
        chk("async_rst_step", int'(bus.step), 0);
        check_state("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        begin
            int ns, fe;
            run_window(0, '0, 0, ns, fe);
            chk("midrst_steps", ns, 0);
            check_state("midrst");
        end

        // Leaving reset with both pins high looks like 00 -> 11.
        reset = 1'b1;
        drive_pair(2'b11);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_pos = 2; m_err = 1'b1;
        begin
            int ns, fe;
            run_window(0, '0, 0, ns, fe);
            chk("rst11_steps", ns, 0);
            check_state("rst11");
        end
        do_op(0, 1'b1, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
